dmem_responder: RTL

Memory-side responder for the CPU's memory-stage load/store requests. It accepts one request at a time over a valid/ready request channel and services it against an internal 64-bit-word RAM after a fixed, parameterised latency. It returns read data or a write acknowledgement over a valid/ready response channel. It is the target end of the memory-stage data bus, used as the data memory in simulation and integration.

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready channels,
// serviced against a byte-writable 64-bit-word RAM after a fixed latency.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            wr_q;
  logic [63:0]     addr_q;
  logic [1:0]      size_q;
  logic [7:0]      strobe_q;
  logic [63:0]     data_q;

  logic [63:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   word_idx;
  logic            misaligned;
  logic            out_of_range;
  logic            access_err;
  logic            access_now;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'd1:    misaligned = addr_q[0];
      2'd2:    misaligned = |addr_q[1:0];
      2'd3:    misaligned = |addr_q[2:0];
      default: misaligned = 1'b0;
    endcase
    word_idx     = addr_q[AW+2:3];
    // Any set bit above the index field lands beyond the last word.
    out_of_range = |addr_q[63:AW+3];
    access_err   = misaligned | out_of_range;
    access_now   = (state == WAIT) && (cnt == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            size_q    <= req_size;
            strobe_q  <= req_strobe;
            data_q    <= req_data;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_err   <= access_err;
            resp_data  <= (!wr_q && !access_err) ? mem[word_idx] : '0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the RAM array has no reset; its contents are undefined until written.
  // A store discarded by reset never writes because reset forces state out of WAIT.
  always_ff @(posedge clk) begin
    if (access_now && wr_q && !access_err) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[word_idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule
